bpu_update_scheduler: RTL

//  Buffers branch-predictor training updates (BHT counter + BTB entry) coming out of the
//  int writeback pipe register and drains them into the shared predictor SRAM write port.

---
 rtl/bpu_update_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bpu_update_scheduler.sv
// Update FIFO between intwb and the shared BHT/BTB write port.
// Frontend lookups win the port unless the head has waited STARVE_LIM cycles.
module bpu_update_scheduler #(
  parameter int DEPTH      = 4,
  parameter int IDX_W      = 9,
  parameter int BTB_W      = 129,
  parameter int STARVE_LIM = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_bht_we,
  input  logic [IDX_W-1:0] up_bht_idx,
  input  logic [1:0]       up_bht_sel,
  input  logic             up_bht_inc,
  input  logic             up_bht_dec,
  input  logic             up_bht_vld,
  input  logic             up_btb_we,
  input  logic [8:0]       up_btb_idx,
  input  logic [BTB_W-1:0] up_btb_wmask,
  input  logic [BTB_W-1:0] up_btb_din,
  input  logic             fe_lookup,
  output logic             fe_stall,
  output logic             bht_we,
  output logic [IDX_W-1:0] bht_idx,
  output logic [1:0]       bht_sel,
  output logic             bht_inc,
  output logic             bht_dec,
  output logic             bht_vld,
  output logic             btb_ce,
  output logic             btb_we,
  output logic [8:0]       btb_idx,
  output logic [BTB_W-1:0] btb_wmask,
  output logic [BTB_W-1:0] btb_din,
  output logic             q_full,
  output logic             q_empty,
  output logic [15:0]      drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
  localparam logic [WW-1:0] LIM    = WW'(STARVE_LIM);

  logic             r_bv    [DEPTH];
  logic [IDX_W-1:0] r_bidx  [DEPTH];
  logic [1:0]       r_bsel  [DEPTH];
  logic             r_binc  [DEPTH];
  logic             r_bdec  [DEPTH];
  logic             r_bvld  [DEPTH];
  logic             r_cv    [DEPTH];
  logic [8:0]       r_cidx  [DEPTH];
  logic [BTB_W-1:0] r_cmask [DEPTH];
  logic [BTB_W-1:0] r_cdin  [DEPTH];

  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic [WW-1:0]    r_wait;
  logic [15:0]      r_drop;

  logic             r_stall;
  logic             r_bht_we;
  logic [IDX_W-1:0] r_bht_idx;
  logic [1:0]       r_bht_sel;
  logic             r_bht_inc;
  logic             r_bht_dec;
  logic             r_bht_vld;
  logic             r_btb_we;
  logic [8:0]       r_btb_idx;
  logic [BTB_W-1:0] r_btb_wmask;
  logic [BTB_W-1:0] r_btb_din;

  logic w_req;
  logic w_head_v;
  logic w_starved;
  logic w_full;
  logic w_pop;
  logic w_enq;
  logic w_drop;
  logic w_bgo;
  logic w_cgo;

  assign w_req     = up_bht_we | up_btb_we;
  assign w_head_v  = (r_count != '0);
  assign w_starved = (r_wait == LIM);
  assign w_full    = (r_count == FULL_N);
  assign w_pop     = w_head_v & (~fe_lookup | w_starved);
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_enq     = w_req & (~w_full | w_pop);
  assign w_drop    = w_req & w_full & ~w_pop;
  assign w_bgo     = w_pop & r_bv[r_rp];
  assign w_cgo     = w_pop & r_cv[r_rp];

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_bv[r_wp]    <= up_bht_we;
      r_bidx[r_wp]  <= up_bht_idx;
      r_bsel[r_wp]  <= up_bht_sel;
      r_binc[r_wp]  <= up_bht_inc;
      r_bdec[r_wp]  <= up_bht_dec;
      r_bvld[r_wp]  <= up_bht_vld;
      r_cv[r_wp]    <= up_btb_we;
      r_cidx[r_wp]  <= up_btb_idx;
      r_cmask[r_wp] <= up_btb_wmask;
      r_cdin[r_wp]  <= up_btb_din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_wait  <= '0;
      r_drop  <= '0;
    end else begin
      if (w_enq) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      unique case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop || !w_head_v) r_wait <= '0;
      else if (!w_starved)    r_wait <= r_wait + WW'(1);
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall     <= 1'b0;
      r_bht_we    <= 1'b0;
      r_bht_idx   <= '0;
      r_bht_sel   <= '0;
      r_bht_inc   <= 1'b0;
      r_bht_dec   <= 1'b0;
      r_bht_vld   <= 1'b0;
      r_btb_we    <= 1'b0;
      r_btb_idx   <= '0;
      r_btb_wmask <= '0;
      r_btb_din   <= '0;
    end else begin
      r_stall     <= w_pop & w_starved;
      r_bht_we    <= w_bgo;
      r_bht_idx   <= w_bgo ? r_bidx[r_rp] : '0;
      r_bht_sel   <= w_bgo ? r_bsel[r_rp] : '0;
      r_bht_inc   <= w_bgo & r_binc[r_rp];
      r_bht_dec   <= w_bgo & r_bdec[r_rp];
      r_bht_vld   <= w_bgo & r_bvld[r_rp];
      r_btb_we    <= w_cgo;
      r_btb_idx   <= w_cgo ? r_cidx[r_rp] : '0;
      r_btb_wmask <= w_cgo ? r_cmask[r_rp] : '0;
      r_btb_din   <= w_cgo ? r_cdin[r_rp] : '0;
    end
  end

  assign fe_stall  = r_stall;
  assign bht_we    = r_bht_we;
  assign bht_idx   = r_bht_idx;
  assign bht_sel   = r_bht_sel;
  assign bht_inc   = r_bht_inc;
  assign bht_dec   = r_bht_dec;
  assign bht_vld   = r_bht_vld;
  assign btb_ce    = r_btb_we;
  assign btb_we    = r_btb_we;
  assign btb_idx   = r_btb_idx;
  assign btb_wmask = r_btb_wmask;
  assign btb_din   = r_btb_din;
  assign q_full    = w_full;
  assign q_empty   = ~w_head_v;
  assign drop_cnt  = r_drop;

endmodule
